cvae_init_loader: RTL and testbench



---
 rtl/cvae_init_loader_if.sv | 50 +++++
 rtl/cvae_init_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_cvae_init_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cvae_init_loader_if.sv
// Bus bundle for the CVAE initial-data loader: the burst input, the mirrored
// state-SRAM write port, the bank read ports and the core's state-update port.
interface cvae_init_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  // Burst capture
  logic                  start;
  logic [DATA_WIDTH-1:0] init_data;
  logic                  busy;
  logic                  load_done;

  // State SRAM mirror write port
  logic                  sram_state_wea;
  logic [ADDR_WIDTH-1:0] sram_state_addr;
  logic [DATA_WIDTH-1:0] sram_state_wdata;

  // Combinational bank read ports
  logic [3:0]            state_raddr;
  logic [DATA_WIDTH-1:0] state_rdata;
  logic [2:0]            goal_raddr;
  logic [DATA_WIDTH-1:0] goal_rdata;
  logic [1:0]            z_raddr;
  logic [DATA_WIDTH-1:0] z_rdata;

  // Core write-back of a new state word
  logic                  upd_en;
  logic [3:0]            upd_addr;
  logic [DATA_WIDTH-1:0] upd_data;

  // Burst source / compute core side
  modport master (
    output start, init_data,
    output state_raddr, goal_raddr, z_raddr,
    output upd_en, upd_addr, upd_data,
    input  busy, load_done,
    input  sram_state_wea, sram_state_addr, sram_state_wdata,
    input  state_rdata, goal_rdata, z_rdata
  );

  // Loader side
  modport slave (
    input  start, init_data,
    input  state_raddr, goal_raddr, z_raddr,
    input  upd_en, upd_addr, upd_data,
    output busy, load_done,
    output sram_state_wea, sram_state_addr, sram_state_wdata,
    output state_rdata, goal_rdata, z_rdata
  );
endinterface

// File: rtl/cvae_init_loader.sv
// CVAE front-end loader. A start pulse opens a 23-word capture window:
// 13 state words, 6 goal words, 4 latent-Z words, held in register banks for
// the compute core. State words are also mirrored into the state SRAM through
// a registered write port. Between bursts the core may overwrite state words.
module cvae_init_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    N_STATE    = 13,
  parameter int                    N_GOAL     = 6,
  parameter int                    N_Z        = 4,
  parameter logic [ADDR_WIDTH-1:0] STATE_BASE = '0
) (
  input logic               clk,
  input logic               rst_n,
  cvae_init_loader_if.slave bus
);

  localparam logic [4:0] LAST_STATE = 5'(N_STATE - 1);
  localparam logic [4:0] LAST_GOAL  = 5'(N_GOAL - 1);
  localparam logic [4:0] LAST_Z     = 5'(N_Z - 1);
  localparam logic [3:0] N_STATE_A  = 4'(N_STATE);

  typedef enum logic [2:0] {
    IDLE,
    LD_STATE,
    LD_GOAL,
    LD_Z,
    DONE
  } fsm_t;

  fsm_t       state_reg, state_next;
  logic [4:0] cnt_reg, cnt_next;

  logic cap_state, cap_goal, cap_z, upd_ok;

  logic [DATA_WIDTH-1:0] state_bank [N_STATE];
  logic [DATA_WIDTH-1:0] goal_bank  [N_GOAL];
  logic [DATA_WIDTH-1:0] z_bank     [N_Z];

  logic [N_STATE-1:0]    state_we;
  logic [N_GOAL-1:0]     goal_we;
  logic [N_Z-1:0]        z_we;
  logic [DATA_WIDTH-1:0] state_wdata;

  // Read tables padded to the full address range so out-of-range reads give 0
  logic [DATA_WIDTH-1:0] state_rd_tab [16];
  logic [DATA_WIDTH-1:0] goal_rd_tab  [8];
  logic [DATA_WIDTH-1:0] z_rd_tab     [4];

  logic                  sram_wea_reg;
  logic [ADDR_WIDTH-1:0] sram_addr_reg;
  logic [DATA_WIDTH-1:0] sram_wdata_reg;

  // FSM state and word counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state / counter logic; start is only honoured from IDLE
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = LD_STATE;
          cnt_next   = '0;
        end
      end
      LD_STATE: begin
        if (cnt_reg == LAST_STATE) begin
          state_next = LD_GOAL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      LD_GOAL: begin
        if (cnt_reg == LAST_GOAL) begin
          state_next = LD_Z;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      LD_Z: begin
        if (cnt_reg == LAST_Z) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign cap_state = (state_reg == LD_STATE);
  assign cap_goal  = (state_reg == LD_GOAL);
  assign cap_z     = (state_reg == LD_Z);

  // Core updates only land in IDLE, lose to a simultaneous start, and are
  // dropped for addresses beyond the state bank.
  assign upd_ok = (state_reg == IDLE) && bus.upd_en && !bus.start &&
                  (bus.upd_addr < N_STATE_A);

  // Per-word write enables
  genvar gi;
  generate
    for (gi = 0; gi < N_STATE; gi++) begin : g_state_we
      assign state_we[gi] = (cap_state && (cnt_reg == 5'(gi))) ||
                            (upd_ok && (bus.upd_addr == 4'(gi)));
    end
    for (gi = 0; gi < N_GOAL; gi++) begin : g_goal_we
      assign goal_we[gi] = cap_goal && (cnt_reg == 5'(gi));
    end
    for (gi = 0; gi < N_Z; gi++) begin : g_z_we
      assign z_we[gi] = cap_z && (cnt_reg == 5'(gi));
    end
  endgenerate

  // Capture and update never coincide, so one mux feeds the state bank
  assign state_wdata = cap_state ? bus.init_data : bus.upd_data;

  // State bank: burst capture plus core write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_STATE; i++) state_bank[i] <= '0;
    end else begin
      for (int i = 0; i < N_STATE; i++) begin
        if (state_we[i]) state_bank[i] <= state_wdata;
      end
    end
  end

  // Goal bank: burst capture only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_GOAL; i++) goal_bank[i] <= '0;
    end else begin
      for (int i = 0; i < N_GOAL; i++) begin
        if (goal_we[i]) goal_bank[i] <= bus.init_data;
      end
    end
  end

  // Latent-Z bank: burst capture only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_Z; i++) z_bank[i] <= '0;
    end else begin
      for (int i = 0; i < N_Z; i++) begin
        if (z_we[i]) z_bank[i] <= bus.init_data;
      end
    end
  end

  // Build the zero-padded read tables
  generate
    for (gi = 0; gi < 16; gi++) begin : g_state_rd
      if (gi < N_STATE) begin : g_word
        assign state_rd_tab[gi] = state_bank[gi];
      end else begin : g_zero
        assign state_rd_tab[gi] = '0;
      end
    end
    for (gi = 0; gi < 8; gi++) begin : g_goal_rd
      if (gi < N_GOAL) begin : g_word
        assign goal_rd_tab[gi] = goal_bank[gi];
      end else begin : g_zero
        assign goal_rd_tab[gi] = '0;
      end
    end
    for (gi = 0; gi < 4; gi++) begin : g_z_rd
      if (gi < N_Z) begin : g_word
        assign z_rd_tab[gi] = z_bank[gi];
      end else begin : g_zero
        assign z_rd_tab[gi] = '0;
      end
    end
  endgenerate

  assign bus.state_rdata = state_rd_tab[bus.state_raddr];
  assign bus.goal_rdata  = goal_rd_tab[bus.goal_raddr];
  assign bus.z_rdata     = z_rd_tab[bus.z_raddr];

  // Registered SRAM mirror: one write per captured state word. Address and
  // data hold their last value once the write enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_wea_reg   <= 1'b0;
      sram_addr_reg  <= '0;
      sram_wdata_reg <= '0;
    end else begin
      sram_wea_reg <= cap_state;
      if (cap_state) begin
        sram_addr_reg  <= STATE_BASE + ADDR_WIDTH'(cnt_reg);
        sram_wdata_reg <= bus.init_data;
      end
    end
  end

  assign bus.sram_state_wea   = sram_wea_reg;
  assign bus.sram_state_addr  = sram_addr_reg;
  assign bus.sram_state_wdata = sram_wdata_reg;

  assign bus.busy      = cap_state || cap_goal || cap_z;
  assign bus.load_done = (state_reg == DONE);

endmodule

// File: tb/tb_cvae_init_loader.sv
// Self-checking bench for cvae_init_loader: directed scenarios plus randomized
// bursts and updates, compared against a word-level model of the three banks
// and of the external state SRAM.
module tb_cvae_init_loader;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NS = 13;
  localparam int NG = 6;
  localparam int NZ = 4;
  localparam int NW = NS + NG + NZ;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cvae_init_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cvae_init_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .N_STATE   (NS),
    .N_GOAL    (NG),
    .N_Z       (NZ),
    .STATE_BASE(16'd0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [31:0] exp_state [NS];
  logic [31:0] exp_goal  [NG];
  logic [31:0] exp_z     [NZ];
  logic [31:0] sram_mem  [int];
  int wr_count   = 0;
  int done_count = 0;
  int done_cyc   = -1;
  int cyc        = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // External SRAM and load_done observer, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sram_state_wea) begin
        sram_mem[int'(bus.sram_state_addr)] = bus.sram_state_wdata;
        wr_count++;
      end
      if (bus.load_done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_model();
    for (int j = 0; j < NS; j++) exp_state[j] = '0;
    for (int j = 0; j < NG; j++) exp_goal[j] = '0;
    for (int j = 0; j < NZ; j++) exp_z[j] = '0;
  endtask

  // Sweep every read address of all three banks against the model
  task automatic check_banks(input string tag);
    logic [31:0] e;
    for (int a = 0; a < 16; a++) begin
      bus.state_raddr = 4'(a);
      bus.goal_raddr  = 3'(a);
      bus.z_raddr     = 2'(a);
      @(negedge clk);
      e = (a < NS) ? exp_state[a] : 32'h0;
      check_val({tag, "_state_rd"}, bus.state_rdata, e);
      if (a < 8) begin
        e = (a < NG) ? exp_goal[a] : 32'h0;
        check_val({tag, "_goal_rd"}, bus.goal_rdata, e);
      end
      if (a < 4) check_val({tag, "_z_rd"}, bus.z_rdata, exp_z[a]);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check_val({tag, "_load_done"}, 32'(bus.load_done), 32'h0);
    check_val({tag, "_wea"}, 32'(bus.sram_state_wea), 32'h0);
    check_val({tag, "_addr"}, 32'(bus.sram_state_addr), 32'h0);
    check_val({tag, "_wdata"}, bus.sram_state_wdata, 32'h0);
  endtask

  // One core update in IDLE; visible on state_rdata the next cycle
  task automatic do_update(input int addr, input logic [31:0] data);
    bus.upd_en      = 1'b1;
    bus.upd_addr    = 4'(addr);
    bus.upd_data    = data;
    bus.state_raddr = 4'(addr);
    @(negedge clk);
    bus.upd_en = 1'b0;
    if (addr < NS) exp_state[addr] = data;
    check_val("upd_read", bus.state_rdata, (addr < NS) ? exp_state[addr] : 32'h0);
    $display("update addr=%0d data=0x%08h", addr, data);
  endtask

  // Full burst; optional re-start pulse, mid-burst reset, or colliding update.
  // Entered and left on a falling edge.
  task automatic do_burst(input bit nominal, input int restart_word,
                          input int reset_word, input bit collide);
    logic [31:0] w [NW];
    logic [31:0] got;
    int wr0, dn0, start_cyc;
    for (int i = 0; i < NW; i++) w[i] = nominal ? (32'h1000 + 32'(i)) : $urandom;
    wr0 = wr_count;
    dn0 = done_count;

    bus.start = 1'b1;
    if (collide) begin
      bus.upd_en      = 1'b1;
      bus.upd_addr    = 4'd5;
      bus.upd_data    = 32'hDEADBEEF;
      bus.state_raddr = 4'd5;
    end
    @(negedge clk);
    start_cyc = cyc;
    if (collide) check_val("collide_upd_dropped", bus.state_rdata, exp_state[5]);
    check_val("busy_after_start", 32'(bus.busy), 32'h1);

    for (int i = 0; i < NW; i++) begin
      bus.init_data = w[i];
      bus.start     = (i == restart_word);
      // Updates while the loader owns the banks must be ignored
      bus.upd_en    = 1'($urandom_range(0, 1));
      bus.upd_addr  = 4'($urandom_range(0, 15));
      bus.upd_data  = $urandom;
      if (i < NS) bus.state_raddr = 4'(i);
      else if (i < NS + NG) bus.goal_raddr = 3'(i - NS);
      else bus.z_raddr = 2'(i - NS - NG);

      if (i == reset_word) begin
        bus.start  = 1'b0;
        bus.upd_en = 1'b0;
        rst_n      = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_outputs_zero("post_reset");
        check_val("post_reset_no_done", 32'(done_count - dn0), 32'h0);
        check_banks("post_reset");
        $display("burst aborted by reset at word %0d", i);
        return;
      end

      @(negedge clk);
      if (i < NS) begin
        exp_state[i] = w[i];
        check_val("state_capture", bus.state_rdata, w[i]);
      end else if (i < NS + NG) begin
        exp_goal[i - NS] = w[i];
        check_val("goal_capture", bus.goal_rdata, w[i]);
      end else begin
        exp_z[i - NS - NG] = w[i];
        check_val("z_capture", bus.z_rdata, w[i]);
      end
      check_val("busy", 32'(bus.busy), 32'(i < NW - 1));
      check_val("load_done_timing", 32'(bus.load_done), 32'(i == NW - 1));
    end

    bus.start  = 1'b0;
    bus.upd_en = 1'b0;
    @(negedge clk);
    check_val("load_done_width", 32'(bus.load_done), 32'h0);
    check_val("done_latency", 32'(done_cyc - start_cyc), 32'd23);
    check_val("done_count", 32'(done_count - dn0), 32'h1);
    check_val("sram_write_count", 32'(wr_count - wr0), 32'd13);
    for (int i = 0; i < NS; i++) begin
      got = sram_mem.exists(i) ? sram_mem[i] : 32'hxxxxxxxx;
      check_val("sram_word", got, w[i]);
    end
    $display("burst done: w0=0x%08h w22=0x%08h restart=%0d collide=%0d",
             w[0], w[NW-1], restart_word, collide);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start       = 1'b0;
    bus.init_data   = '0;
    bus.state_raddr = '0;
    bus.goal_raddr  = '0;
    bus.z_raddr     = '0;
    bus.upd_en      = 1'b0;
    bus.upd_addr    = '0;
    bus.upd_data    = '0;
    clear_model();

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("after_reset");
    check_banks("reset");

    // Nominal burst 0x1000+i
    do_burst(1'b1, -1, -1, 1'b0);
    check_banks("nominal");
    bus.state_raddr = 4'd15;
    bus.goal_raddr  = 3'd7;
    bus.z_raddr     = 2'd3;
    @(negedge clk);
    check_val("oor_state", bus.state_rdata, 32'h0);
    check_val("oor_goal", bus.goal_rdata, 32'h0);
    check_val("z3_read", bus.z_rdata, 32'h1016);

    // State update and out-of-range update
    do_update(5, 32'hDEADBEEF);
    do_update(13, 32'h12345678);
    check_banks("update");

    // Re-start during burst at word 7
    do_burst(1'b0, 7, -1, 1'b0);
    check_banks("restart");

    // Reset at word 16, then a fresh burst
    do_burst(1'b0, -1, 16, 1'b0);
    do_burst(1'b0, -1, -1, 1'b0);
    check_banks("fresh");

    // Update and start on the same edge
    do_burst(1'b0, -1, -1, 1'b1);
    check_banks("collide");

    // Randomized updates and bursts
    for (int r = 0; r < 6; r++) begin
      for (int u = 0; u < 5; u++) do_update($urandom_range(0, 15), $urandom);
      check_banks("rand_upd");
      do_burst(1'b0, ($urandom_range(0, 1) == 1) ? $urandom_range(0, NW - 1) : -1, -1, 1'b0);
      check_banks("rand_burst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
